expected_in_accum: RTL and testbench

- Clocked backpropagation stage that sits directly downstream of the learning neurons of one layer.
- Collects the per-input `expected_in` vectors that each neuron of a layer produces, one neuron per beat.
- At the end of the group, computes the per-lane mean. The mean vector is presented as `expected_out` targets for the N upstream neurons.
- Division runs serially through one shared restoring divider.

---
 rtl/expected_in_accum_pkg.sv | 17 +
 rtl/expected_in_accum_serial_udiv.sv | 68 ++++++
 rtl/expected_in_accum.sv | 135 +++++++++++++
 tb/tb_expected_in_accum.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/expected_in_accum_pkg.sv
// Shared types for the expected_in accumulation stage: the zero-to-one fixed-point
// lane type and the accumulator state encoding.
package expected_in_accum_pkg;

    localparam int ZERO2ONE_W = 8;

    typedef logic [ZERO2ONE_W-1:0] zero2one_t;

    localparam zero2one_t ZERO2ONE_MAX = '1;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIVIDE = 2'd1,
        OUTPUT = 2'd2
    } accum_state_t;

endpackage

// File: rtl/expected_in_accum_serial_udiv.sv
// Serial restoring unsigned divider: one load cycle on start, then DW shift/subtract
// cycles; done pulses for one cycle with the quotient valid. Divisor must be non-zero.
module serial_udiv #(
    parameter int DW = 12,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient
);

    localparam int CW = $clog2(DW + 1);

    logic [CW-1:0] cnt;
    logic [VW-1:0] rem;
    logic [DW-1:0] quo;
    logic [VW:0]   rem_sh;
    logic [VW-1:0] diff;
    logic          ge;
    logic          load;

    assign load = start && !busy;

    always_comb begin
        rem_sh = {rem, quo[DW-1]};
        ge     = (rem_sh >= {1'b0, divisor});
        // When ge holds the true difference is below divisor, so the low VW bits are exact.
        diff   = rem_sh[VW-1:0] - divisor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                busy <= 1'b1;
                cnt  <= CW'(DW);
            end else if (busy) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rem <= '0;
            quo <= dividend;
        end else if (busy) begin
            rem <= ge ? diff : rem_sh[VW-1:0];
            quo <= {quo[DW-2:0], ge};
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/expected_in_accum.sv
// Accumulates one layer's expected_in vectors and emits the per-lane mean as expected_out.
// Define EXPECTED_ACCUM_ROUND_EN for round-half-up (clamped) instead of truncating division.
module expected_in_accum
    import expected_in_accum_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  zero2one_t [N-1:0]     s_expected_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output zero2one_t [N-1:0]     m_expected_out,
    output logic [$clog2(M+1)-1:0] m_count,
    output logic                  overflow_err
);

    localparam int CNT_W = $clog2(M + 1);
`ifdef EXPECTED_ACCUM_ROUND_EN
    localparam int ACC_W = ZERO2ONE_W + CNT_W + 1;
`else
    localparam int ACC_W = ZERO2ONE_W + CNT_W;
`endif
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    accum_state_t   state;
    logic [ACC_W-1:0] acc [N];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic [KW-1:0]    k;
    logic [KW-1:0]    lane_sel;

    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [ACC_W-1:0] div_dividend;
    logic [ACC_W-1:0] div_quotient;

    function automatic zero2one_t sat_q(input logic [ACC_W-1:0] q);
        if (q > ACC_W'(ZERO2ONE_MAX))
            return ZERO2ONE_MAX;
        return q[ZERO2ONE_W-1:0];
    endfunction

`ifdef EXPECTED_ACCUM_ROUND_EN
    function automatic logic [ACC_W-1:0] div_operand(input logic [ACC_W-1:0] a,
                                                     input logic [CNT_W-1:0] c);
        return a + ACC_W'(c >> 1);
    endfunction
`else
    function automatic logic [ACC_W-1:0] div_operand(input logic [ACC_W-1:0] a);
        return a;
    endfunction
`endif

    assign s_ready   = (state == ACCUM);
    assign count_inc = count + CNT_W'(1);

    // The capture edge of lane k doubles as the load edge of lane k+1.
    assign lane_sel  = div_done ? k + KW'(1) : k;
    assign div_start = (state == DIVIDE) && !div_busy && !(div_done && k == KW'(N - 1));
`ifdef EXPECTED_ACCUM_ROUND_EN
    assign div_dividend = div_operand(acc[lane_sel], count);
`else
    assign div_dividend = div_operand(acc[lane_sel]);
`endif

    serial_udiv #(
        .DW(ACC_W),
        .VW(CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (count),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ACCUM;
            for (int i = 0; i < N; i++) acc[i] <= '0;
            count          <= '0;
            k              <= '0;
            m_valid        <= 1'b0;
            m_expected_out <= '0;
            m_count        <= '0;
            overflow_err   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (s_valid) begin
                        for (int i = 0; i < N; i++)
                            acc[i] <= acc[i] + ACC_W'(s_expected_in[i]);
                        count <= count_inc;
                        if (s_last || count_inc == CNT_W'(M)) begin
                            state <= DIVIDE;
                            k     <= '0;
                        end
                        if (!s_last && count_inc == CNT_W'(M))
                            overflow_err <= 1'b1;
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        m_expected_out[k] <= sat_q(div_quotient);
                        k <= k + KW'(1);
                        if (k == KW'(N - 1)) begin
                            state   <= OUTPUT;
                            m_valid <= 1'b1;
                            m_count <= count;
                        end
                    end
                end
                OUTPUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        for (int i = 0; i < N; i++) acc[i] <= '0;
                        count   <= '0;
                        state   <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_expected_in_accum.sv
// Directed and randomised bench for expected_in_accum at N=4, M=4, W=8.
module tb_expected_in_accum;

    localparam int N     = 4;
    localparam int M     = 4;
    localparam int W     = 8;
    localparam int CNT_W = $clog2(M + 1);
`ifdef EXPECTED_ACCUM_ROUND_EN
    localparam int ACC_W = W + CNT_W + 1;
`else
    localparam int ACC_W = W + CNT_W;
`endif
    localparam int LAT   = N * (ACC_W + 1) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic             m_ready = 1'b0;
    logic [N*W-1:0]   s_data = '0;
    logic             s_ready;
    logic             m_valid;
    logic             overflow_err;
    logic [N*W-1:0]   m_data;
    logic [CNT_W-1:0] m_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    expected_in_accum #(.N(N), .M(M)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_last         (s_last),
        .s_expected_in  (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_expected_out (m_data),
        .m_count        (m_count),
        .overflow_err   (overflow_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic send_beat(input logic [N*W-1:0] vec, input logic last, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = vec;
        s_last  = last;
        t = 0;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) chk("beat_taken", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!m_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic take_out(input string tag);
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk({tag, "_mvalid_drop"}, m_valid, 0);
        chk({tag, "_sready_back"}, s_ready, 1);
    endtask

    initial begin
        int cyc;
        int seen;
        int bad;
        logic [N*W-1:0] snap;
        logic [CNT_W-1:0] snapc;
        logic [N*W-1:0] vec;
        logic [N*W-1:0] exp_v;
        int sums [N];
        int nb;
        int e;

        // Reset state
        #12;
        chk("rst_sready", s_ready, 1);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mcount", m_count, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_ovf", overflow_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of DIVIDE drops the group
        send_beat(pk(1, 2, 3, 4), 1'b1, 0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        chk("middiv_rst_sready", s_ready, 1);
        seen = 0;
        repeat (LAT + 10) begin
            @(posedge clk);
            #1;
            if (m_valid) seen = 1;
        end
        chk("middiv_no_output", seen, 0);
        send_beat(pk(9, 9, 9, 9), 1'b1, 0);
        wait_out(cyc);
        chk("after_rst_data", m_data, pk(9, 9, 9, 9));
        chk("after_rst_count", m_count, 1);
        take_out("after_rst");

        // Single beat passes through unchanged, exact latency
        send_beat(pk(10, 20, 30, 255), 1'b1, 0);
        wait_out(cyc);
        chk("single_latency", cyc, LAT);
        chk("single_data", m_data, pk(10, 20, 30, 255));
        chk("single_count", m_count, 1);
        take_out("single");

        // Two beats: truncating vs rounding mean
        send_beat(pk(255, 0, 100, 3), 1'b0, 0);
        send_beat(pk(255, 0, 101, 4), 1'b1, 0);
        wait_out(cyc);
        chk("two_latency", cyc, LAT);
`ifdef EXPECTED_ACCUM_ROUND_EN
        chk("two_data", m_data, pk(255, 0, 101, 4));
`else
        chk("two_data", m_data, pk(255, 0, 100, 3));
`endif
        chk("two_count", m_count, 2);
        chk("two_ovf", overflow_err, 0);
        take_out("two");

        // M beats with no s_last closes the group and flags overflow
        repeat (4) send_beat(pk(200, 200, 200, 200), 1'b0, 0);
        wait_out(cyc);
        chk("ovf_latency", cyc, LAT);
        chk("ovf_data", m_data, pk(200, 200, 200, 200));
        chk("ovf_count", m_count, 4);
        chk("ovf_flag", overflow_err, 1);
        take_out("ovf");

        // Backpressure on the output: everything holds, input beats ignored
        send_beat(pk(8, 16, 24, 32), 1'b0, 0);
        send_beat(pk(0, 0, 0, 1), 1'b1, 0);
        wait_out(cyc);
`ifdef EXPECTED_ACCUM_ROUND_EN
        chk("hold_data", m_data, pk(4, 8, 12, 17));
`else
        chk("hold_data", m_data, pk(4, 8, 12, 16));
`endif
        chk("hold_count", m_count, 2);
        snap  = m_data;
        snapc = m_count;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = pk(100, 100, 100, 100);
        s_last  = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (m_data !== snap || m_count !== snapc || !m_valid || s_ready) bad++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("hold_stable", bad, 0);
        take_out("hold");
        send_beat(pk(7, 7, 7, 7), 1'b1, 0);
        wait_out(cyc);
        chk("cleared_data", m_data, pk(7, 7, 7, 7));
        chk("cleared_count", m_count, 1);
        take_out("cleared");

        // Random groups with source gaps
        for (int g = 0; g < 6; g++) begin
            nb = $urandom_range(1, 4);
            for (int i = 0; i < N; i++) sums[i] = 0;
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < N; i++) begin
                    vec[i*W +: W] = W'($urandom_range(0, 255));
                    sums[i] += int'(vec[i*W +: W]);
                end
                send_beat(vec, (b == nb - 1), $urandom_range(0, 2));
            end
            wait_out(cyc);
            chk("rand_latency", cyc, LAT);
            for (int i = 0; i < N; i++) begin
`ifdef EXPECTED_ACCUM_ROUND_EN
                e = (sums[i] + nb / 2) / nb;
                if (e > 255) e = 255;
`else
                e = sums[i] / nb;
`endif
                exp_v[i*W +: W] = W'(e);
            end
            chk("rand_data", m_data, exp_v);
            chk("rand_count", m_count, nb);
            take_out("rand");
        end
        chk("ovf_sticky", overflow_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
